merge2_arb: RTL and testbench
=============================

Name: merge2_arb

Overview:
- Two-input merge/arbiter for the async NoC. It is the inverse of the 1-to-2 address decoder.
- Accepts whole packets from two input channels and arbitrates them round-robin. It forwards each packet on a single output channel.
- Before each packet it emits a 1-bit source token on S, so downstream logic can pair the token with the packet.
- Sits behind the standard RECV/SEND 1ofN wrappers. All channels here are RTL-side valid/ready handshakes.

Parameters:
- W, 9, packet width in bits (matches e1of2_9 channel).
- CNT_W, 16, width of each per-input forwarded-packet counter (saturating).

Ports:
- CLK  input  1  clock
- _RESET  input  1  reset
- In0_data  input  W  packet from input 0
- In0_valid  input  1  input 0 packet available
- In0_ready  output  1  input 0 packet accepted this cycle
- In1_data  input  W  packet from input 1
- In1_valid  input  1  input 1 packet available
- In1_ready  output  1  input 1 packet accepted this cycle
- S_data  output  1  source token (0 = In0, 1 = In1)
- S_valid  output  1  token valid
- S_ready  input  1  token consumed
- Out_data  output  W  forwarded packet
- Out_valid  output  1  packet valid
- Out_ready  input  1  packet consumed
- cnt0  output  CNT_W  packets forwarded from In0
- cnt1  output  CNT_W  packets forwarded from In1

Behaviour:
- Reset: _RESET asynchronous, active-low; clock CLK, rising edge. All outputs, state and counters are 0; state = IDLE; prio = 0 (In0 preferred); held packet register = 0.
- Handshake: a transfer occurs on a rising edge where valid && ready. Producers hold valid and data stable until the transfer. Outputs obey the same rule: S_valid/S_data and Out_valid/Out_data stay stable until consumed.
- FSM has three states: IDLE, SEND_S, SEND_OUT.
- IDLE: In0_ready and In1_ready are combinational and asserted only here, only for the granted input.
  - Grant rule: if only In0_valid, grant 0. If only In1_valid, grant 1. If both, grant prio. If neither, no ready and stay in IDLE.
  - On the grant edge: capture data into the held register, winner into sel, then go to SEND_S.
- SEND_S: S_valid = 1, S_data = sel. When S_ready is high, go to SEND_OUT.
- SEND_OUT: Out_valid = 1, Out_data = held register. When Out_ready is high:
  - prio <= ~sel;
  - the counter for sel increments, saturating at 2^CNT_W-1;
  - go to IDLE.
- Ordering: the token transfer always strictly precedes its packet transfer. Token and packet are never valid in the same cycle.
- Latency and throughput:
  - With ready always high: accept at edge N, S transfer at N+1, Out transfer at N+2.
  - Next accept no earlier than N+3, so minimum 3 cycles per packet.
  - No input is accepted while a packet is in flight (single-packet buffer).
- Fairness: with both inputs continuously valid, grants strictly alternate. A lone requester is never blocked by prio.
- Simultaneous events: a new valid arriving in SEND_S or SEND_OUT waits. Arbitration uses valids sampled in IDLE only. prio changes only on Out completion.
- Backpressure: S_ready or Out_ready low holds the state indefinitely, with no data change and no counter change.
- Reset mid-operation: any in-flight packet and token are dropped, counters clear, prio returns to 0, and no partial output remains.
- Counters: update only on completed Out transfers. At saturation they hold their value; there is no wrap.

Test Plan:
- In0 alone sends 0x1A5 with all readies high: In0_ready pulses at cycle 0, S=0 transfers at cycle 1, Out=0x1A5 transfers at cycle 2, cnt0=1, cnt1=0.
- Both valid continuously (In0=0x011, In1=0x122) for 4 packets: S sequence is 0,1,0,1 and Out sequence is 0x011,0x122,0x011,0x122; cnt0=cnt1=2.
- In1 sends 0x0F0 with S_ready held low for 5 cycles: S_valid=1 and S_data=1 stable throughout, Out_valid=0, no In ready asserted. Release → Out=0x0F0 the next cycle.
- Out_ready held low 4 cycles after S transfer: Out_valid and Out_data stable, In0_valid=1 is not accepted; counter increments only on the release edge.
- CNT_W=2, 5 In0 packets: cnt0 reads 1,2,3,3,3 (saturates, no wrap).
- Assert _RESET mid-SEND_OUT: outputs are 0 immediately (asynchronously); after deassert the FSM is in IDLE, prio=0, counters=0. With both inputs valid, the first grant goes to In0.

Source files
------------

// File: rtl/merge2_arb.sv
// Two-input round-robin packet merge; each packet is preceded by a 1-bit source token on S.
// Latency: accept at edge N, token transfer at N+1, packet transfer at N+2; next accept no earlier than N+3.
// Backpressure: S_ready/Out_ready low holds the FSM, data and counters; inputs see no ready while a packet is in flight.
//
// Ports:
//   CLK, _RESET        clock (rising edge), asynchronous active-low reset
//   In0_* / In1_*      input packet channels (valid/ready), W bits each
//   S_*                source token channel (0 = In0, 1 = In1)
//   Out_*              merged packet channel, W bits
//   cnt0 / cnt1        saturating counts of packets forwarded from each input

module merge2_arb #(
    parameter int W     = 9,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             _RESET,
    input  logic [W-1:0]     In0_data,
    input  logic             In0_valid,
    output logic             In0_ready,
    input  logic [W-1:0]     In1_data,
    input  logic             In1_valid,
    output logic             In1_ready,
    output logic             S_data,
    output logic             S_valid,
    input  logic             S_ready,
    output logic [W-1:0]     Out_data,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_S   = 2'd1,
        SEND_OUT = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         prio;      // input preferred when both request
    logic         sel;       // input whose packet is currently held
    logic [W-1:0] held;
    logic         grant0;
    logic         grant1;

    // A lone requester always wins; prio only breaks ties.
    assign grant0 = In0_valid && (!In1_valid || !prio);
    assign grant1 = In1_valid && (!In0_valid ||  prio);

    // Held registers are only loaded in IDLE, so these stay stable
    // for the whole token and packet phases.
    assign S_data   = sel;
    assign Out_data = held;

    always_comb begin
        state_nxt = state;
        In0_ready = 1'b0;
        In1_ready = 1'b0;
        S_valid   = 1'b0;
        Out_valid = 1'b0;
        case (state)
            IDLE: begin
                In0_ready = grant0;
                In1_ready = grant1;
                if (grant0 || grant1) begin
                    state_nxt = SEND_S;
                end
            end
            SEND_S: begin
                S_valid = 1'b1;
                if (S_ready) begin
                    state_nxt = SEND_OUT;
                end
            end
            SEND_OUT: begin
                Out_valid = 1'b1;
                if (Out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state <= IDLE;
            prio  <= 1'b0;
            sel   <= 1'b0;
            held  <= '0;
            cnt0  <= '0;
            cnt1  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (grant0 || grant1)) begin
                held <= grant0 ? In0_data : In1_data;
                sel  <= grant1;
            end
            if (state == SEND_OUT && Out_ready) begin
                // Hand priority to the other input only once the packet has left.
                prio <= ~sel;
                if (!sel) begin
                    if (cnt0 != '1) begin
                        cnt0 <= cnt0 + CNT_W'(1);
                    end
                end else begin
                    if (cnt1 != '1) begin
                        cnt1 <= cnt1 + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_merge2_arb.sv
// Directed bench for merge2_arb: a vector table for the basic and alternating flows,
// plus hand-written sequences for backpressure, saturation and mid-flight reset.
// A second instance with CNT_W=2 shares all inputs and is used for counter saturation.

module tb_merge2_arb;

    logic        clk;
    logic        rst_n;
    logic [8:0]  in0_data;
    logic        in0_valid;
    logic        in0_ready;
    logic [8:0]  in1_data;
    logic        in1_valid;
    logic        in1_ready;
    logic        s_data;
    logic        s_valid;
    logic        s_ready;
    logic [8:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    logic        sat_in0_ready;
    logic        sat_in1_ready;
    logic        sat_s_data;
    logic        sat_s_valid;
    logic [8:0]  sat_out_data;
    logic        sat_out_valid;
    logic [1:0]  sat_cnt0;
    logic [1:0]  sat_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    merge2_arb #(.W(9), .CNT_W(16)) dut (
        .CLK       (clk),
        ._RESET    (rst_n),
        .In0_data  (in0_data),
        .In0_valid (in0_valid),
        .In0_ready (in0_ready),
        .In1_data  (in1_data),
        .In1_valid (in1_valid),
        .In1_ready (in1_ready),
        .S_data    (s_data),
        .S_valid   (s_valid),
        .S_ready   (s_ready),
        .Out_data  (out_data),
        .Out_valid (out_valid),
        .Out_ready (out_ready),
        .cnt0      (cnt0),
        .cnt1      (cnt1)
    );

    merge2_arb #(.W(9), .CNT_W(2)) u_sat (
        .CLK       (clk),
        ._RESET    (rst_n),
        .In0_data  (in0_data),
        .In0_valid (in0_valid),
        .In0_ready (sat_in0_ready),
        .In1_data  (in1_data),
        .In1_valid (in1_valid),
        .In1_ready (sat_in1_ready),
        .S_data    (sat_s_data),
        .S_valid   (sat_s_valid),
        .S_ready   (s_ready),
        .Out_data  (sat_out_data),
        .Out_valid (sat_out_valid),
        .Out_ready (out_ready),
        .cnt0      (sat_cnt0),
        .cnt1      (sat_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [8:0]  d0;
        logic        v1;
        logic [8:0]  d1;
        logic        sr;
        logic        orr;
        logic        e_r0;
        logic        e_r1;
        logic        e_sv;
        logic        e_sd;
        logic        e_ov;
        logic [8:0]  e_od;
        logic [15:0] e_c0;
        logic [15:0] e_c1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic v0, logic [8:0] d0, logic v1, logic [8:0] d1,
                                logic sr, logic orr, logic e_r0, logic e_r1, logic e_sv,
                                logic e_sd, logic e_ov, logic [8:0] e_od,
                                logic [15:0] e_c0, logic [15:0] e_c1);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.sr = sr; v.orr = orr; v.e_r0 = e_r0; v.e_r1 = e_r1;
        v.e_sv = e_sv; v.e_sd = e_sd; v.e_ov = e_ov; v.e_od = e_od;
        v.e_c0 = e_c0; v.e_c1 = e_c1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reset pulse spanning one rising edge; returns at posedge+1.
    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = '0;
        in1_data  = '0;
        s_ready   = 1'b1;
        out_ready = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;

        // Reset state, sampled while reset is still asserted.
        chk("rst_s_valid",   32'(s_valid),   32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_in0_ready", 32'(in0_ready), 32'd0);
        chk("rst_cnt0",      32'(cnt0),      32'd0);
        chk("rst_cnt1",      32'(cnt1),      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // In0 alone sends 0x1A5 with all readies high.
        vecs.push_back(mk(1, 1,9'h1A5, 0,9'h000, 1,1, 1,0, 0,0, 0,9'h000, 0,0));
        vecs.push_back(mk(0, 0,9'h000, 0,9'h000, 1,1, 0,0, 1,0, 0,9'h000, 0,0));
        vecs.push_back(mk(0, 0,9'h000, 0,9'h000, 1,1, 0,0, 0,0, 1,9'h1A5, 0,0));
        vecs.push_back(mk(0, 0,9'h000, 0,9'h000, 1,1, 0,0, 0,0, 0,9'h000, 1,0));
        // Both inputs continuously valid: grants alternate 0,1,0,1.
        vecs.push_back(mk(1, 1,9'h011, 1,9'h122, 1,1, 1,0, 0,0, 0,9'h000, 0,0));
        vecs.push_back(mk(0, 1,9'h011, 1,9'h122, 1,1, 0,0, 1,0, 0,9'h000, 0,0));
        vecs.push_back(mk(0, 1,9'h011, 1,9'h122, 1,1, 0,0, 0,0, 1,9'h011, 0,0));
        vecs.push_back(mk(0, 1,9'h011, 1,9'h122, 1,1, 0,1, 0,0, 0,9'h000, 1,0));
        vecs.push_back(mk(0, 1,9'h011, 1,9'h122, 1,1, 0,0, 1,1, 0,9'h000, 1,0));
        vecs.push_back(mk(0, 1,9'h011, 1,9'h122, 1,1, 0,0, 0,0, 1,9'h122, 1,0));
        vecs.push_back(mk(0, 1,9'h011, 1,9'h122, 1,1, 1,0, 0,0, 0,9'h000, 1,1));
        vecs.push_back(mk(0, 1,9'h011, 1,9'h122, 1,1, 0,0, 1,0, 0,9'h000, 1,1));
        vecs.push_back(mk(0, 1,9'h011, 1,9'h122, 1,1, 0,0, 0,0, 1,9'h011, 1,1));
        vecs.push_back(mk(0, 1,9'h011, 1,9'h122, 1,1, 0,1, 0,0, 0,9'h000, 2,1));
        vecs.push_back(mk(0, 1,9'h011, 1,9'h122, 1,1, 0,0, 1,1, 0,9'h000, 2,1));
        vecs.push_back(mk(0, 1,9'h011, 1,9'h122, 1,1, 0,0, 0,0, 1,9'h122, 2,1));
        vecs.push_back(mk(0, 0,9'h000, 0,9'h000, 1,1, 0,0, 0,0, 0,9'h000, 2,2));

        foreach (vecs[i]) begin
            if (vecs[i].rst) pulse_reset();
            in0_valid = vecs[i].v0;
            in0_data  = vecs[i].d0;
            in1_valid = vecs[i].v1;
            in1_data  = vecs[i].d1;
            s_ready   = vecs[i].sr;
            out_ready = vecs[i].orr;
            @(negedge clk);
            chk($sformatf("v%0d_in0_ready", i), 32'(in0_ready), 32'(vecs[i].e_r0));
            chk($sformatf("v%0d_in1_ready", i), 32'(in1_ready), 32'(vecs[i].e_r1));
            chk($sformatf("v%0d_s_valid", i),   32'(s_valid),   32'(vecs[i].e_sv));
            if (vecs[i].e_sv)
                chk($sformatf("v%0d_s_data", i), 32'(s_data), 32'(vecs[i].e_sd));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov)
                chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
            chk($sformatf("v%0d_cnt0", i), 32'(cnt0), 32'(vecs[i].e_c0));
            chk($sformatf("v%0d_cnt1", i), 32'(cnt1), 32'(vecs[i].e_c1));
            @(posedge clk);
            #1;
        end

        // In1 sends 0x0F0 with S_ready held low for 5 cycles.
        idle_inputs();
        pulse_reset();
        in1_valid = 1'b1;
        in1_data  = 9'h0F0;
        s_ready   = 1'b0;
        @(negedge clk);
        chk("sbp_in1_ready", 32'(in1_ready), 32'd1);
        @(posedge clk);
        #1;
        in1_valid = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 9'h033;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("sbp%0d_s_valid", c),   32'(s_valid),   32'd1);
            chk($sformatf("sbp%0d_s_data", c),    32'(s_data),    32'd1);
            chk($sformatf("sbp%0d_out_valid", c), 32'(out_valid), 32'd0);
            chk($sformatf("sbp%0d_in0_ready", c), 32'(in0_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in0_valid = 1'b0;
        s_ready   = 1'b1;
        @(negedge clk);
        chk("sbp_rel_s_valid", 32'(s_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("sbp_out_valid", 32'(out_valid), 32'd1);
        chk("sbp_out_data",  32'(out_data),  32'h0F0);
        chk("sbp_s_clear",   32'(s_valid),   32'd0);
        @(posedge clk);
        #1;
        chk("sbp_cnt1", 32'(cnt1), 32'd1);
        chk("sbp_cnt0", 32'(cnt0), 32'd0);

        // Out_ready held low for 4 cycles after the token transfer.
        idle_inputs();
        pulse_reset();
        in0_valid = 1'b1;
        in0_data  = 9'h055;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("obp%0d_out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("obp%0d_out_data", c),  32'(out_data),  32'h055);
            chk($sformatf("obp%0d_in0_ready", c), 32'(in0_ready), 32'd0);
            chk($sformatf("obp%0d_cnt0", c),      32'(cnt0),      32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("obp_rel_cnt0_before", 32'(cnt0), 32'd0);
        @(posedge clk);
        #1;
        chk("obp_rel_cnt0_after", 32'(cnt0), 32'd1);
        // prio now favours In1, but a lone In0 request must still be granted.
        @(negedge clk);
        chk("obp_lone_in0_ready", 32'(in0_ready), 32'd1);
        in0_valid = 1'b0;
        @(posedge clk);
        #1;

        // Saturation: CNT_W=2 instance sees 5 In0 packets.
        idle_inputs();
        pulse_reset();
        in0_valid = 1'b1;
        in0_data  = 9'h007;
        for (int p = 0; p < 5; p++) begin
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("sat%0d_cnt0", p), 32'(sat_cnt0), 32'((p + 1 > 3) ? 3 : p + 1));
            chk($sformatf("wide%0d_cnt0", p), 32'(cnt0), 32'(p + 1));
        end
        in0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset during SEND_OUT with prio pointing at In1.
        idle_inputs();
        pulse_reset();
        in0_valid = 1'b1;
        in0_data  = 9'h0AA;
        repeat (3) @(posedge clk);
        #1;
        in0_valid = 1'b0;
        in1_valid = 1'b1;
        in1_data  = 9'h155;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("mrst_pre_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_data",  32'(out_data),  32'd0);
        chk("mrst_s_valid",   32'(s_valid),   32'd0);
        chk("mrst_cnt0",      32'(cnt0),      32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        @(negedge clk);
        chk("mrst_grant_in0", 32'(in0_ready), 32'd1);
        chk("mrst_grant_in1", 32'(in1_ready), 32'd0);
        chk("mrst_cnt1",      32'(cnt1),      32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
